// File: rtl/img_frame_tx_pkg.sv
// rtl/img_frame_tx_pkg.sv - shared frame definitions for the image frame transmitter and parser
package img_frame_tx_pkg;

  // FSM state encodings, shared with the receive-side frame parser
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_LENH  = 3'd2,
    S_LENL  = 3'd3,
    S_FETCH = 3'd4,
    S_DATA  = 3'd5,
    S_CSUM  = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hAA;
  localparam int         LEN_FIELD_W  = 16;

  // States that present a byte to the UART TX FIFO
  function automatic logic is_emit(input state_t s);
    return (s == S_HDR) || (s == S_LENH) || (s == S_LENL) ||
           (s == S_DATA) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/img_frame_tx.sv
// rtl/img_frame_tx.sv - framed image transmitter feeding the UART TX FIFO
module img_frame_tx
  import img_frame_tx_pkg::*;
#(
  parameter int         ADDR_W   = 12,
  parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  input  logic              tx_full,
  output logic              wr_uart,
  output logic [7:0]        w_data,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = ADDR_W + 1;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic [ADDR_W-1:0]      addr_q;
  logic [ADDR_W-1:0]      addr_d;
  logic [ADDR_W-1:0]      mem_addr_q;
  logic [7:0]             sum_q;
  logic [LEN_FIELD_W-1:0] len_q;

  assign cnt_d    = cnt_q - CNT_W'(1);
  assign addr_d   = addr_q + ADDR_W'(1);
  assign mem_addr = mem_addr_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

  // Byte mux and write strobe; the strobe follows tx_full combinationally so a
  // full FIFO stalls the current byte without losing a cycle on release.
  // In DATA the read address is held, so mem_data stays stable across stalls.
  always_comb begin
    w_data = 8'h00;
    case (state_q)
      S_HDR:   w_data = HDR_BYTE;
      S_LENH:  w_data = len_q[15:8];
      S_LENL:  w_data = len_q[7:0];
      S_DATA:  w_data = mem_data;
      S_CSUM:  w_data = sum_q;
      default: w_data = 8'h00;
    endcase
    wr_uart = is_emit(state_q) && !tx_full;
  end

  // Frame sequencer: advances emit states only on an accepted byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      mem_addr_q <= '0;
      sum_q      <= '0;
      len_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_q   <= len;
            addr_q  <= '0;
            sum_q   <= '0;
            len_q   <= LEN_FIELD_W'(len);
            state_q <= S_HDR;
          end
        end
        S_HDR: begin
          if (wr_uart) state_q <= S_LENH;
        end
        S_LENH: begin
          if (wr_uart) begin
            sum_q   <= sum_q + w_data;
            state_q <= S_LENL;
          end
        end
        S_LENL: begin
          if (wr_uart) begin
            sum_q <= sum_q + w_data;
            if (cnt_q != '0) begin
              mem_addr_q <= addr_q;
              state_q    <= S_FETCH;
            end else begin
              state_q <= S_CSUM;
            end
          end
        end
        S_FETCH: begin
          state_q <= S_DATA;
        end
        S_DATA: begin
          if (wr_uart) begin
            sum_q <= sum_q + w_data;
            cnt_q <= cnt_d;
            // addr stops at len-1 so it never wraps inside a full-size frame
            if (cnt_d != '0) begin
              addr_q     <= addr_d;
              mem_addr_q <= addr_d;
              state_q    <= S_FETCH;
            end else begin
              state_q <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (wr_uart) state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_frame_tx.sv
// tb/tb_img_frame_tx.sv - scoreboard bench for img_frame_tx
module tb_img_frame_tx;

  localparam int ADDR_W = 12;

  typedef struct {
    logic [7:0] b;
    int         addr;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   len = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data = 8'h00;
  logic              tx_full = 1'b0;
  logic              wr_uart;
  logic [7:0]        w_data;
  logic              busy;
  logic              done;

  logic [7:0] mem [4096];
  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;

  img_frame_tx #(.ADDR_W(ADDR_W), .HDR_BYTE(8'hAA)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .start    (start),
    .len      (len),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .tx_full  (tx_full),
    .wr_uart  (wr_uart),
    .w_data   (w_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // synchronous one-cycle-latency image buffer
  always @(posedge clk) mem_data <= mem[mem_addr];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b, input int addr);
    exp_t e;
    e.b = b;
    e.addr = addr;
    q.push_back(e);
  endtask

  // monitor: every accepted byte is popped and compared
  always @(negedge clk) begin
    if (rst_n && wr_uart) begin
      if (q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("w_data", w_data, e.b);
        if (e.addr >= 0) check("mem_addr", mem_addr, e.addr);
      end
    end
  end

  // Runs one frame; times done from the start-sampling edge E0
  task automatic run_frame(input int n, input int stall_byte, input bit pulse, input int exp_edges);
    int edges;
    int stall_left;
    bit stalled;
    bit seen_done;
    edges = 0; stall_left = 0; stalled = 0; seen_done = 0;
    @(posedge clk); #1;
    start = 1'b1;
    len = (ADDR_W+1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    while (!seen_done && edges < 20000) begin
      start = pulse && (edges == 1 || edges == 4);
      if (stall_byte >= 0 && !stalled && wr_uart && w_data == stall_byte[7:0]) begin
        tx_full = 1'b1;
        stalled = 1;
        stall_left = 5;
      end
      @(posedge clk); #1;
      edges++;
      if (tx_full) begin
        check("stall_wr_low", wr_uart, 0);
        check("stall_w_data", w_data, stall_byte);
        stall_left--;
        if (stall_left == 0) tx_full = 1'b0;
      end
      if (pulse && !done) check("busy_continuous", busy, 1);
      if (done) seen_done = 1;
    end
    start = 1'b0;
    check("done_latency", edges, exp_edges);
    @(posedge clk); #1;
    check("busy_after_done", busy, 0);
    check("done_pulse_width", done, 0);
    check("queue_drained", q.size(), 0);
  endtask

  initial begin
    int w;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_wr_uart", wr_uart, 0);
    check("reset_w_data", w_data, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst_n = 1'b1;

    // short frame
    mem[0] = 8'h0A; mem[1] = 8'h14; mem[2] = 8'h1E;
    push(8'hAA, -1); push(8'h00, -1); push(8'h03, -1);
    push(8'h0A, 0); push(8'h14, 1); push(8'h1E, 2); push(8'h3F, -1);
    run_frame(3, -1, 0, 10);

    // empty frame
    push(8'hAA, -1); push(8'h00, -1); push(8'h00, -1); push(8'h00, -1);
    run_frame(0, -1, 0, 4);

    // backpressure on data byte 0x14
    push(8'hAA, -1); push(8'h00, -1); push(8'h03, -1);
    push(8'h0A, 0); push(8'h14, 1); push(8'h1E, 2); push(8'h3F, -1);
    run_frame(3, 8'h14, 0, 15);

    // start while busy
    push(8'hAA, -1); push(8'h00, -1); push(8'h02, -1);
    push(8'h0A, 0); push(8'h14, 1); push(8'h20, -1);
    run_frame(2, -1, 1, 8);

    // reset in DATA after 2 of 5 data bytes
    mem[3] = 8'h28; mem[4] = 8'h32;
    push(8'hAA, -1); push(8'h00, -1); push(8'h05, -1);
    push(8'h0A, 0); push(8'h14, 1);
    @(posedge clk); #1;
    start = 1'b1;
    len = 13'd5;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (!(wr_uart && w_data == 8'h1E) && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("reach_third_data", (w < 100) ? 1 : 0, 1);
    rst_n = 1'b0;
    #1;
    check("rst_wr_uart", wr_uart, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_queue_drained", q.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(8'hAA, -1); push(8'h00, -1); push(8'h01, -1);
    push(8'h0A, 0); push(8'h0B, -1);
    run_frame(1, -1, 0, 6);

    // full-size frame
    for (int i = 0; i < 4096; i++) mem[i] = i[7:0];
    push(8'hAA, -1); push(8'h10, -1); push(8'h00, -1);
    for (int i = 0; i < 4096; i++) push(i[7:0], i);
    push(8'h10, -1);
    run_frame(4096, -1, 0, 8196);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
